// File: rtl/key_pkg.sv
// Shared types and default timing for the key conditioner: repeat FSM states
// and the nominal clock/tick/debounce/repeat constants.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    localparam int DEF_CLK_HZ             = 50_000_000;
    localparam int DEF_TICK_HZ            = 1000;
    localparam int DEF_DEBOUNCE_TICKS     = 20;
    localparam int DEF_REPEAT_DELAY_TICKS = 400;
    localparam int DEF_REPEAT_RATE_TICKS  = 100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Shared time base: one-cycle tick every CLK_HZ/TICK_HZ clocks (at least every clock).
module tick_gen
    import key_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/key_array_cond.sv
// Multi-key conditioner: synchronise, debounce, edge pulses and per-key
// auto-repeat producing a single action strobe per key.
module key_array_cond
    import key_pkg::*;
#(
    parameter int N_KEYS             = 3,
    parameter int CLK_HZ             = DEF_CLK_HZ,
    parameter int TICK_HZ            = DEF_TICK_HZ,
    parameter int DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
    parameter int ACTIVE_LOW         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_act
);

    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RP_MAX = max_int(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS);
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LIM   = DB_W'(DEBOUNCE_TICKS);
    localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY_TICKS);
    localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE_TICKS);
    // Pin level of a released key; synchronisers reset to it so reset never looks like a press.
    localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

    logic tick;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    genvar k;
    generate
        for (k = 0; k < N_KEYS; k++) begin : g_key
            logic            sync_p0, sync_p1;
            logic            key_s;
            logic [DB_W-1:0] db_cnt;
            logic            level_q, press_q, release_q, act_q;
            logic            accept, press_ev, release_ev;
            rpt_state_t      state;
            logic [RP_W-1:0] rp_cnt;
            logic            paused;

            // Stage p0/p1: two-flop synchroniser on the raw pin
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_p0 <= PIN_IDLE;
                    sync_p1 <= PIN_IDLE;
                end else begin
                    sync_p0 <= key_in[k];
                    sync_p1 <= sync_p0;
                end
            end

            assign key_s      = sync_p1 ^ PIN_IDLE;
            assign accept     = (key_s != level_q) && (db_cnt == DB_LIM);
            assign press_ev   = accept && !level_q;
            assign release_ev = accept && level_q;

            // Debounce: count ticks of disagreement, toggle once the limit is held
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    db_cnt    <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    press_q   <= press_ev;
                    release_q <= release_ev;
                    if (key_s == level_q) begin
                        db_cnt <= '0;
                    end else if (accept) begin
                        level_q <= ~level_q;
                        db_cnt  <= '0;
                    end else if (tick) begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
            end

            // Repeat FSM; paused marks a counter parked at 0 by repeat_en=0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state  <= IDLE;
                    rp_cnt <= '0;
                    paused <= 1'b0;
                    act_q  <= 1'b0;
                end else begin
                    act_q <= press_ev;
                    case (state)
                        IDLE: begin
                            if (press_ev) begin
                                state  <= DELAY;
                                rp_cnt <= RP_DELAY;
                                paused <= 1'b0;
                            end
                        end
                        DELAY, REPEAT: begin
                            if (release_ev) begin
                                state  <= IDLE;
                                rp_cnt <= '0;
                                paused <= 1'b0;
                            end else if (!repeat_en[k]) begin
                                rp_cnt <= '0;
                                paused <= 1'b1;
                            end else if (paused) begin
                                state  <= REPEAT;
                                rp_cnt <= RP_RATE;
                                paused <= 1'b0;
                            end else if (rp_cnt == '0) begin
                                state  <= REPEAT;
                                rp_cnt <= RP_RATE;
                                act_q  <= 1'b1;
                            end else if (tick) begin
                                rp_cnt <= rp_cnt - RP_W'(1);
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            rp_cnt <= '0;
                            paused <= 1'b0;
                        end
                    endcase
                end
            end

            assign key_level[k]   = level_q;
            assign key_press[k]   = press_q;
            assign key_release[k] = release_q;
            assign key_act[k]     = act_q;
        end
    endgenerate

endmodule

// File: tb/tb_key_array_cond.sv
// Scoreboard bench for key_array_cond: stimulus queues expected pulses by cycle,
// a negedge monitor compares whatever the DUT presents against the queue.
module tb_key_array_cond;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_in = 3'b111;
    logic [2:0] repeat_en = 3'b000;
    logic [2:0] key_level, key_press, key_release, key_act;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] a;
    } exp_t;
    exp_t sb[$];

    logic [2:0] mon_p, mon_r, mon_a;

    always #5 clk = ~clk;

    key_array_cond #(
        .N_KEYS             (3),
        .CLK_HZ             (10000),
        .TICK_HZ            (1000),
        .DEBOUNCE_TICKS     (3),
        .REPEAT_DELAY_TICKS (5),
        .REPEAT_RATE_TICKS  (2),
        .ACTIVE_LOW         (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .repeat_en   (repeat_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_act     (key_act)
    );

    // cyc = number of rising edges since reset was released
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Ticks are sampled on edges 11, 21, 31, ... after reset release.
    function automatic int next_tick(input int e);
        int t = e;
        while (t < 11 || (t % 10) != 1) t++;
        return t;
    endfunction

    // Pin changed at the negedge where cyc==n: sampled after 2 sync flops at edge n+3,
    // three ticks of stability, then the level toggles on the following edge.
    function automatic int edge_time(input int n);
        return next_tick(n + 3) + 21;
    endfunction

    task automatic expect_ev(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] a);
        exp_t x;
        x.cyc = c;
        x.p = p;
        x.r = r;
        x.a = a;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   32'(key_level),   32'd0);
        check({tag, "_press"},   32'(key_press),   32'd0);
        check({tag, "_release"}, 32'(key_release), 32'd0);
        check({tag, "_act"},     32'(key_act),     32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_p = 3'b000;
            mon_r = 3'b000;
            mon_a = 3'b000;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                if (sb[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_expectation at cycle %0d: due cycle %0d never consumed", cyc, sb[0].cyc);
                end else begin
                    mon_p = mon_p | sb[0].p;
                    mon_r = mon_r | sb[0].r;
                    mon_a = mon_a | sb[0].a;
                end
                void'(sb.pop_front());
            end
            if ((mon_p | mon_r | mon_a | key_press | key_release | key_act) != 3'b000) begin
                check("mon_press",   32'(key_press),   32'(mon_p));
                check("mon_release", 32'(key_release), 32'(mon_r));
                check("mon_act",     32'(key_act),     32'(mon_a));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog at cycle %0d: simulation did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, m, p, r, a;

        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("first_cycle");

        // Clean press on key 0
        wait_to(20);
        n = cyc;
        key_in[0] = 1'b0;
        p = edge_time(n);
        r = edge_time(n + 200);
        expect_ev(p, 3'b001, 3'b000, 3'b001);
        expect_ev(r, 3'b000, 3'b001, 3'b000);
        wait_to(p - 1);
        check("clean_level_before", 32'(key_level), 32'b000);
        wait_to(p);
        check("clean_level_after", 32'(key_level), 32'b001);
        wait_to(n + 200);
        key_in[0] = 1'b1;
        wait_to(r);
        check("clean_level_released", 32'(key_level), 32'b000);
        wait_to(r + 10);

        // Bouncing key 1: seven transitions 15 cycles apart, settling low
        n = cyc;
        p = edge_time(n + 90);
        expect_ev(p, 3'b010, 3'b000, 3'b010);
        for (int i = 0; i < 7; i++) begin
            wait_to(n + 15 * i);
            key_in[1] = ((i % 2) == 1);
        end
        wait_to(p - 1);
        check("bounce_level_before", 32'(key_level), 32'b000);
        wait_to(p);
        check("bounce_level_after", 32'(key_level), 32'b010);
        wait_to(p + 50);
        m = cyc;
        key_in[1] = 1'b1;
        r = edge_time(m);
        expect_ev(r, 3'b000, 3'b010, 3'b000);
        wait_to(r + 10);

        // Auto-repeat on key 2; release lands on a due repeat, which must vanish
        repeat_en[2] = 1'b1;
        n = cyc;
        key_in[2] = 1'b0;
        p = edge_time(n);
        r = edge_time(n + 1510);
        expect_ev(p, 3'b100, 3'b000, 3'b100);
        for (int t = p + 50; t < r; t += 20) expect_ev(t, 3'b000, 3'b000, 3'b100);
        expect_ev(r, 3'b000, 3'b100, 3'b000);
        wait_to(n + 1510);
        key_in[2] = 1'b1;
        wait_to(r + 40);
        check("repeat_level_released", 32'(key_level), 32'b000);
        repeat_en[2] = 1'b0;

        // Repeat gating: held with repeat_en=0, then enabled later
        n = cyc;
        key_in[2] = 1'b0;
        p = edge_time(n);
        expect_ev(p, 3'b100, 3'b000, 3'b100);
        wait_to(p + 80);
        m = cyc;
        repeat_en[2] = 1'b1;
        a = next_tick(m + 2) + 11;
        r = edge_time(m + 100);
        for (int t = a; t < r; t += 20) expect_ev(t, 3'b000, 3'b000, 3'b100);
        expect_ev(r, 3'b000, 3'b100, 3'b000);
        wait_to(m + 100);
        key_in[2] = 1'b1;
        wait_to(r + 10);
        repeat_en[2] = 1'b0;

        // Simultaneous press on all keys, then reset mid-hold
        n = cyc;
        key_in = 3'b000;
        p = edge_time(n);
        expect_ev(p, 3'b111, 3'b000, 3'b111);
        wait_to(p);
        check("simul_level", 32'(key_level), 32'b111);
        wait_to(p + 40);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        check("mid_reset_sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p = edge_time(0);
        expect_ev(p, 3'b111, 3'b000, 3'b111);
        @(negedge clk);
        check_all_zero("after_reset");
        wait_to(p - 1);
        check("repress_level_before", 32'(key_level), 32'b000);
        wait_to(p);
        check("repress_level_after", 32'(key_level), 32'b111);
        wait_to(p + 30);
        m = cyc;
        key_in = 3'b111;
        r = edge_time(m);
        expect_ev(r, 3'b000, 3'b111, 3'b000);
        wait_to(r);
        check("final_level", 32'(key_level), 32'b000);
        wait_to(r + 20);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
